// File: rtl/obi_mem_responder.sv
// Single-port OBI memory slave: word-organised RAM at BASE_ADDR that answers
// every granted request, in grant order, exactly LATENCY cycles later.
module obi_mem_responder #(
    parameter int          ADDR_WIDTH = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h0002_0000,
    parameter int          LATENCY    = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    input  logic        stall_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int          DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [32:0] BYTE_SPAN  = 33'd4 << ADDR_WIDTH;

    // Handshake: a request transfers on any rising edge where req_i && gnt_o.
    // The master keeps req/addr/we/be/wdata stable until that edge; every
    // transfer yields exactly one rvalid_o pulse, and there is no back-pressure
    // on the response side.

    logic [31:0]           mem [DEPTH];
    logic [31:0]           off;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  wr_hit;
    logic                  rd_hit;

    logic                  valid_q [LATENCY];
    logic [31:0]           rdata_q [LATENCY];
    logic                  err_q   [LATENCY];

    assign gnt_o    = rst_ni & req_i & ~stall_i;
    assign off      = addr_i - BASE_ADDR;
    assign in_range = ({1'b0, off} < BYTE_SPAN);
    assign word_idx = off[ADDR_WIDTH+1:2];
    assign wr_hit   = gnt_o & we_i & in_range;
    assign rd_hit   = gnt_o & ~we_i & in_range;

    // RAM contents survive reset; gnt_o already blocks writes while in reset.
    always_ff @(posedge clk_i) begin
        if (wr_hit) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                rdata_q[i] <= '0;
                err_q[i]   <= 1'b0;
            end
        end else begin
            valid_q[0] <= gnt_o;
            err_q[0]   <= gnt_o & ~in_range;
            // Nonblocking read sees every write from earlier grant edges.
            if (rd_hit) begin
                rdata_q[0] <= mem[word_idx];
            end else begin
                rdata_q[0] <= '0;
            end
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
                err_q[i]   <= err_q[i-1];
            end
        end
    end

    assign rvalid_o = valid_q[LATENCY-1];
    assign rdata_o  = rdata_q[LATENCY-1];
    assign err_o    = err_q[LATENCY-1];

endmodule
